wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter_pkg.sv | 23 ++
 rtl/wrr_arbiter_rr_pick.sv | 34 +++
 rtl/wrr_arbiter.sv | 148 ++++++++++++++
 tb/tb_wrr_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state encoding, a ceil-log2 helper and the default sizing.
package wrr_arbiter_pkg;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned WW_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    // Ceil-log2 for elaboration-time index widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Wrap-around priority search: returns the first candidate at or after ptr,
// where candidates are requesters that are not excluded.
module rr_pick
    import wrr_arbiter_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    localparam int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic          found_c,
    output logic [IW-1:0] idx_c
);

    logic [N-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        int unsigned j;
        found_c = 1'b0;
        idx_c   = '0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found_c && cand[IW'(j)]) begin
                found_c = 1'b1;
                idx_c   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each grant holds for up to weight[owner]
// cycles, handing over without bubbles whenever anyone else is requesting.
module wrr_arbiter
    import wrr_arbiter_pkg::*;
#(
    parameter  int unsigned N  = N_DEF,
    parameter  int unsigned WW = WW_DEF,
    localparam int unsigned IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [WW-1:0] cfg_wt,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] quant_q, quant_d;
    logic          ready_q, ready_d;
    logic [WW-1:0] weight_q [N];
    logic [WW-1:0] weight_d [N];

    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] pick_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          grant_go;
    logic [IW-1:0] grant_idx;
    logic          go_idle;

    // A zero weight still earns one grant cycle.
    function automatic logic [WW-1:0] eff_wt(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    assign ptr_nxt  = IW'((32'(gnt_id_q) + 32'd1) % N);
    assign pick_ptr = (state_q == ST_OWN) ? ptr_nxt : ptr_q;

    // The owner is excluded so others get first pick; it is re-granted only if alone.
    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .excl    (gnt_q),
        .found_c (pick_found),
        .idx_c   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        quant_d     = quant_q;
        ready_d     = 1'b1;
        weight_d    = weight_q;
        grant_go    = 1'b0;
        grant_idx   = '0;
        go_idle     = 1'b0;

        if (cfg_we && (32'(cfg_idx) < N)) begin
            weight_d[cfg_idx] = cfg_wt;
        end

        case (state_q)
            ST_IDLE: begin
                if (ready_q && pick_found) begin
                    grant_go  = 1'b1;
                    grant_idx = pick_idx;
                end
            end
            ST_OWN: begin
                if (req[gnt_id_q] && (cnt_q != quant_q)) begin
                    cnt_d = cnt_q + WW'(1);
                end else begin
                    ptr_d = ptr_nxt;
                    if (pick_found) begin
                        grant_go  = 1'b1;
                        grant_idx = pick_idx;
                    end else if (req[gnt_id_q]) begin
                        grant_go  = 1'b1;
                        grant_idx = gnt_id_q;
                    end else begin
                        go_idle = 1'b1;
                    end
                end
            end
        endcase

        // Quantum is latched from the stored weight only when a grant starts.
        if (grant_go) begin
            state_d     = ST_OWN;
            gnt_d       = N'(1) << grant_idx;
            gnt_valid_d = 1'b1;
            gnt_id_d    = grant_idx;
            cnt_d       = WW'(1);
            quant_d     = eff_wt(weight_q[grant_idx]);
        end else if (go_idle) begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            gnt_id_d    = '0;
            cnt_d       = '0;
        end
    end

    // ready_q holds off the first grant for one cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            quant_q     <= WW'(1);
            ready_q     <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                weight_q[i] <= WW'(1);
            end
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            quant_q     <= quant_d;
            ready_q     <= ready_d;
            weight_q    <= weight_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed scoreboard bench for wrr_arbiter: expected grants are queued with
// each cycle's stimulus and compared against the registered outputs.
module tb_wrr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [WW-1:0] cfg_wt;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    logic [N-1:0]  exp_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc_no  = 0;

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_wt    (cfg_wt),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] idx_of(input logic [N-1:0] g);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < int'(N); i++) begin
            if (g[i]) r = 32'(i);
        end
        return r;
    endfunction

    // One clock: drive inputs, queue the expected grant, compare after the edge.
    task automatic cyc(input logic r, input logic [N-1:0] rq, input logic we,
                       input logic [IW-1:0] idx, input logic [WW-1:0] wt,
                       input logic [N-1:0] exp);
        logic [N-1:0] e;
        rst     = r;
        req     = rq;
        cfg_we  = we;
        cfg_idx = idx;
        cfg_wt  = wt;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc_no++;
        if (exp_q.size() == 0) begin
            chk_eq($sformatf("c%0d_queue_empty", cyc_no), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk_eq($sformatf("c%0d_gnt", cyc_no), 32'(gnt), 32'(e));
            chk_eq($sformatf("c%0d_valid", cyc_no), 32'(gnt_valid), 32'(e != '0));
            chk_eq($sformatf("c%0d_id", cyc_no), 32'(gnt_id), idx_of(e));
        end
    endtask

    task automatic run(input logic [N-1:0] rq, input logic [N-1:0] exp);
        cyc(1'b0, rq, 1'b0, '0, '0, exp);
    endtask

    task automatic wr(input logic [N-1:0] rq, input logic [IW-1:0] idx,
                      input logic [WW-1:0] wt, input logic [N-1:0] exp);
        cyc(1'b0, rq, 1'b1, idx, wt, exp);
    endtask

    initial begin
        rst = 1'b1; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_wt = '0;

        // reset state
        cyc(1'b1, 4'b0000, 1'b0, '0, '0, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0, '0, '0, 4'b0000);

        // plain round-robin, first grant on the second edge after reset
        run(4'b1111, 4'b0000);
        run(4'b1111, 4'b0001);
        run(4'b1111, 4'b0010);
        run(4'b1111, 4'b0100);
        run(4'b1111, 4'b1000);
        run(4'b1111, 4'b0001);

        // weights 3 and 2 on requesters 0 and 1
        wr(4'b0000, 2'd0, 4'd3, 4'b0000);
        wr(4'b0000, 2'd1, 4'd2, 4'b0000);
        run(4'b0011, 4'b0010);
        run(4'b0011, 4'b0010);
        run(4'b0011, 4'b0001);
        run(4'b0011, 4'b0001);
        run(4'b0011, 4'b0001);
        run(4'b0011, 4'b0010);
        wr(4'b0011, 2'd2, 4'd2, 4'b0010);
        run(4'b0011, 4'b0001);

        // lone requester re-granted back to back
        repeat (5) run(4'b0100, 4'b0100);

        // owner 1 (weight 4) drops early, requester 3 takes over next edge
        wr(4'b0000, 2'd1, 4'd4, 4'b0000);
        run(4'b0010, 4'b0010);
        run(4'b1010, 4'b0010);
        run(4'b1000, 4'b1000);
        run(4'b1000, 4'b1000);

        // weight write during a running quantum applies only to the next grant
        wr(4'b0000, 2'd0, 4'd2, 4'b0000);
        run(4'b0001, 4'b0001);
        wr(4'b0011, 2'd0, 4'd5, 4'b0001);
        repeat (4) run(4'b0011, 4'b0010);
        repeat (5) run(4'b0011, 4'b0001);
        run(4'b0011, 4'b0010);

        // reset mid-quantum drops grant; weights and pointer restart
        run(4'b0011, 4'b0010);
        cyc(1'b1, 4'b0011, 1'b0, '0, '0, 4'b0000);
        run(4'b0011, 4'b0000);
        run(4'b0011, 4'b0001);
        run(4'b0011, 4'b0010);
        run(4'b0011, 4'b0001);

        // weight 0 behaves as a single-cycle quantum
        wr(4'b1000, 2'd3, 4'd0, 4'b1000);
        run(4'b1001, 4'b0001);
        run(4'b1000, 4'b1000);
        run(4'b1001, 4'b0001);
        run(4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
